cp0_irq: RTL and testbench

- Coprocessor-0 for the pipelined MIPS core. It is the CPU-side consumer of the IRQ lines driven by bus peripherals such as the timer/counter.
- Latches hardware interrupt lines and masks them through SR.
- Takes exceptions and interrupts in the M stage, saves EPC, BD and ExcCode, and sets EXL.
- Serves mfc0/mtc0 accesses; eret clears EXL.

---
 rtl/cp0_irq.sv | 95 +++++++++
 tb/tb_cp0_irq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cp0_irq.sv
// rtl/cp0_irq.sv - MIPS coprocessor 0: interrupt latching, exception entry, mfc0/mtc0, eret
// Exceptions and interrupts are taken in the M stage; Req is combinational so the core can flush the same cycle.
module cp0_irq #(
   parameter logic [31:0] PRID = 32'h4255_4141
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] Din,
   input  logic        WE,
   input  logic [31:0] PC,
   input  logic        BD,
   input  logic [4:0]  ExcCode,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic        Req,
   output logic [31:0] EPC,
   output logic [31:0] Dout
);

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic        bd_q;
   logic [5:0]  ip;
   logic [4:0]  exc_code_q;
   logic [31:0] epc_q;

   logic        int_req;
   logic        exc_req;
   logic [31:0] epc_next;
   logic [31:0] sr_word;
   logic [31:0] cause_word;

   // Live HWInt, not the latched IP, so an interrupt is seen the cycle it rises.
   assign int_req  = (|(HWInt & im)) & ie & ~exl;
   assign exc_req  = (ExcCode != 5'd0) & ~exl;
   assign Req      = int_req | exc_req;

   assign epc_next = (BD ? (PC - 32'd4) : PC) & 32'hFFFF_FFFC;

   assign sr_word    = {16'b0, im, 8'b0, exl, ie};
   assign cause_word = {bd_q, 15'b0, ip, 3'b0, exc_code_q, 2'b0};
   assign EPC        = epc_q;

   always_comb begin
      Dout = 32'h0;
      case (A1)
         REG_SR:    Dout = sr_word;
         REG_CAUSE: Dout = cause_word;
         REG_EPC:   Dout = epc_q;
         REG_PRID:  Dout = PRID;
         default:   Dout = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         im         <= 6'd0;
         exl        <= 1'b0;
         ie         <= 1'b0;
         bd_q       <= 1'b0;
         ip         <= 6'd0;
         exc_code_q <= 5'd0;
         epc_q      <= 32'h0;
      end else begin
         ip <= HWInt;
         if (Req) begin
            // The mtc0 in flight is being flushed, so its write is dropped.
            exl        <= 1'b1;
            bd_q       <= BD;
            epc_q      <= epc_next;
            exc_code_q <= int_req ? 5'd0 : ExcCode;
         end else begin
            if (WE && A2 == REG_SR) begin
               im  <= Din[15:10];
               exl <= Din[1];
               ie  <= Din[0];
            end
            if (WE && A2 == REG_EPC)
               epc_q <= {Din[31:2], 2'b00};
            // Placed after the SR write so eret's clear wins over Din[1].
            if (EXLClr)
               exl <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cp0_irq.sv
// tb/tb_cp0_irq.sv - scoreboard bench for cp0_irq with directed and random stimulus
// The driver pushes expected outputs per cycle; a negedge monitor pops and compares.
module tb_cp0_irq;

   localparam logic [31:0] PRID_V = 32'h4255_4141;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  a1, a2, exc_code;
   logic [31:0] din, pc;
   logic        we, bd, exl_clr;
   logic [5:0]  hw_int;
   logic        req;
   logic [31:0] epc, dout;

   typedef struct {
      logic        req;
      logic [31:0] epc;
      logic [31:0] dout;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   logic stim_done = 1'b0;

   logic [31:0] m_sr, m_cause, m_epc;

   cp0_irq #(.PRID(PRID_V)) dut (
      .clk(clk), .reset(reset), .A1(a1), .A2(a2), .Din(din), .WE(we),
      .PC(pc), .BD(bd), .ExcCode(exc_code), .HWInt(hw_int), .EXLClr(exl_clr),
      .Req(req), .EPC(epc), .Dout(dout)
   );

   always #5 clk = ~clk;

   function automatic logic model_int(input logic [5:0] hw);
      return ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic logic model_exc(input logic [4:0] ec);
      return (ec != 5'd0) && !m_sr[1];
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] r);
      case (r)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID_V;
         default: return 32'h0;
      endcase
   endfunction

   // Applies the rules of one clock edge using the inputs held during the cycle just ending.
   task automatic model_edge();
      logic i_r, e_r;
      i_r = model_int(hw_int);
      e_r = model_exc(exc_code);
      if (reset) begin
         m_sr = 0; m_cause = 0; m_epc = 0;
      end else begin
         m_cause = (m_cause & ~32'h0000_FC00) | ({26'b0, hw_int} << 10);
         if (i_r || e_r) begin
            m_sr    = m_sr | 32'h2;
            m_cause = (m_cause & 32'h0000_FC00) | ({31'b0, bd} << 31)
                      | ({27'b0, (i_r ? 5'd0 : exc_code)} << 2);
            m_epc   = (bd ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
         end else begin
            if (we && a2 == 5'd12) m_sr  = din & 32'h0000_FC03;
            if (we && a2 == 5'd14) m_epc = din & 32'hFFFF_FFFC;
            if (exl_clr)           m_sr  = m_sr & ~32'h2;
         end
      end
   endtask

   task automatic step(input logic rst, input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic [31:0] rdin, input logic rwe, input logic [31:0] rpc,
                       input logic rbd, input logic [4:0] rexc, input logic [5:0] rhw,
                       input logic rclr);
      exp_t e;
      @(posedge clk);
      #1;
      model_edge();
      reset = rst; a1 = ra1; a2 = ra2; din = rdin; we = rwe; pc = rpc;
      bd = rbd; exc_code = rexc; hw_int = rhw; exl_clr = rclr;
      e.req  = model_int(rhw) || model_exc(rexc);
      e.epc  = m_epc;
      e.dout = model_read(ra1);
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sb_req", {31'b0, req}, {31'b0, e.req});
         chk("sb_epc", epc, e.epc);
         chk("sb_dout", dout, e.dout);
      end
   end

   initial begin
      reset = 1'b1; a1 = 0; a2 = 0; din = 0; we = 0; pc = 0; bd = 0;
      exc_code = 0; hw_int = 6'h3F; exl_clr = 0;
      m_sr = 0; m_cause = 0; m_epc = 0;

      step(1, 5'd15, 0, 0, 0, 0, 0, 0, 6'h3F, 0);
      step(1, 5'd15, 0, 0, 0, 0, 0, 0, 6'h3F, 0);
      #1 chk("reset_req", {31'b0, req}, 32'h0);
      chk("reset_prid", dout, PRID_V);
      step(0, 5'd12, 0, 0, 0, 0, 0, 0, 6'h00, 0);
      #1 chk("reset_sr", dout, 32'h0);
      step(0, 5'd13, 0, 0, 0, 0, 0, 0, 6'h00, 0);
      #1 chk("reset_cause", dout, 32'h0);
      step(0, 5'd14, 0, 0, 0, 0, 0, 0, 6'h00, 0);
      #1 chk("reset_epc", dout, 32'h0);
      step(0, 5'd15, 0, 0, 0, 0, 0, 0, 6'h00, 0);
      #1 chk("read_prid", dout, PRID_V);

      // Enable timer interrupt, then take it.
      step(0, 5'd12, 5'd12, 32'h0000_0401, 1, 0, 0, 0, 6'h01, 0);
      step(0, 5'd13, 0, 0, 0, 32'h0000_3010, 0, 0, 6'h01, 0);
      #1 chk("int_req", {31'b0, req}, 32'h1);
      step(0, 5'd13, 0, 0, 0, 0, 0, 0, 6'h01, 0);
      #1 chk("int_epc", epc, 32'h0000_3010);
      chk("int_cause", dout, 32'h0000_0400);
      chk("exl_blocks", {31'b0, req}, 32'h0);
      step(0, 5'd12, 0, 0, 0, 0, 0, 0, 6'h01, 1);
      #1 chk("exl_set_sr", dout, 32'h0000_0403);
      step(0, 5'd12, 0, 0, 0, 32'h0000_3014, 0, 0, 6'h01, 0);
      #1 chk("req_after_eret", {31'b0, req}, 32'h1);

      // Exception in a delay slot with IE=0.
      step(0, 5'd12, 5'd12, 32'h0, 1, 0, 0, 0, 6'h00, 0);
      step(0, 5'd13, 0, 0, 0, 32'h0000_3024, 1, 5'd10, 6'h00, 0);
      #1 chk("exc_req", {31'b0, req}, 32'h1);
      step(0, 5'd13, 0, 0, 0, 0, 0, 0, 6'h00, 0);
      #1 chk("exc_epc", epc, 32'h0000_3020);
      chk("exc_cause", dout, 32'h8000_0028);

      // Interrupt beats a simultaneous exception.
      step(0, 5'd12, 5'd12, 32'h0000_1001, 1, 0, 0, 0, 6'h00, 0);
      step(0, 5'd13, 0, 0, 0, 32'h0000_3030, 0, 5'd4, 6'h04, 0);
      step(0, 5'd13, 0, 0, 0, 0, 0, 0, 6'h00, 0);
      #1 chk("prio_cause", dout, 32'h0000_1000);

      // mtc0 EPC is dropped when Req fires, applied otherwise.
      step(0, 5'd12, 5'd12, 32'h0000_1001, 1, 0, 0, 0, 6'h00, 0);
      step(0, 5'd14, 5'd14, 32'h0000_3107, 1, 32'h0000_3040, 0, 5'd4, 6'h00, 0);
      step(0, 5'd14, 5'd14, 32'h0000_3107, 1, 0, 0, 0, 6'h00, 0);
      #1 chk("epc_flushed_write", epc, 32'h0000_3040);
      step(0, 5'd14, 0, 0, 0, 0, 0, 0, 6'h00, 0);
      #1 chk("epc_write", epc, 32'h0000_3104);

      for (int i = 0; i < 3000; i++) begin
         logic [4:0] ra1, ra2, rexc;
         logic [31:0] rdin;
         ra1  = 5'd10 + 5'($urandom_range(0, 6));
         ra2  = 5'd11 + 5'($urandom_range(0, 4));
         rdin = $urandom;
         if ($urandom_range(0, 3) == 0) rdin[1] = 1'b0;
         rexc = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
         step(($urandom_range(0, 63) == 0), ra1, ra2, rdin, ($urandom_range(0, 2) == 0),
              $urandom & 32'hFFFF_FFFC, 1'($urandom), rexc,
              ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0,
              ($urandom_range(0, 4) == 0));
      end
      stim_done = 1'b1;
   end

   initial begin
      int budget;
      budget = 0;
      while (!(stim_done && exp_q.size() == 0) && budget < 20000) begin
         @(posedge clk);
         budget++;
      end
      if (budget >= 20000) begin
         checks++;
         failures++;
         $display("FAIL timeout: pending %0d expected 0", exp_q.size());
      end
      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
